// File: rtl/ln_pkg.sv
// Shared definitions for the fixed-point natural-log datapath: constants, width helpers
// and the range-reduction payload seen by the downstream stages.
package ln_pkg;

  // ln(2) in Q0.16, used by the e*ln2 recombine stage.
  localparam int LN2_Q16 = 45426;

  localparam int LN_INT_WIDTH  = 4;
  localparam int LN_FRAC_WIDTH = 4;
  localparam int LN_DATA_WIDTH = LN_INT_WIDTH + LN_FRAC_WIDTH;

  function automatic int exp_width(input int dw);
    return $clog2(dw) + 1;
  endfunction

  localparam int LN_EXP_WIDTH = exp_width(LN_DATA_WIDTH);

  typedef struct packed {
    logic [LN_DATA_WIDTH-2:0] frac;
    logic [LN_EXP_WIDTH-1:0]  exp;
    logic                     zero;
  } ln_rr_t;

endpackage

// File: rtl/leading_one_detect.sv
// Combinational priority encoder: index of the most significant set bit, plus an all-zero flag.
module leading_one_detect #(
  parameter int WIDTH     = 8,
  parameter int POS_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     data,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 zero
);

  // NOTE: pos gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) pos = POS_WIDTH'(i);
    end
  end

  assign zero = (data == '0);

endmodule

// File: rtl/ln_range_reduce.sv
// Range reduction X = 2^e * (1+f) ahead of the ln(1+x) polynomial; two-stage valid/ready
// pipeline with full backpressure and no skid buffer.
module ln_range_reduce
  import ln_pkg::*;
#(
  parameter int INT_WIDTH  = 4,
  parameter int FRAC_WIDTH = 4,
  parameter int DATA_WIDTH = INT_WIDTH + FRAC_WIDTH,
  parameter int EXP_WIDTH  = exp_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-2:0] out_frac,
  output logic [EXP_WIDTH-1:0]  out_exp,
  output logic                  out_zero,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int POS_WIDTH = $clog2(DATA_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-2:0] frac;
    logic [EXP_WIDTH-1:0]  exp;
    logic                  zero;
  } payload_t;

  logic                  out_adv;
  logic                  s1_adv;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [POS_WIDTH-1:0]  s1_pos;
  logic                  s1_zero;
  logic [POS_WIDTH-1:0]  lod_pos;
  logic                  lod_zero;
  logic [POS_WIDTH-1:0]  shamt;
  payload_t              out_d;
  payload_t              out_q;

  // A stage may load whenever its successor frees up in the same cycle.
  assign out_adv  = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || out_adv;
  assign in_ready = s1_adv;

  leading_one_detect #(
    .WIDTH    (DATA_WIDTH),
    .POS_WIDTH(POS_WIDTH)
  ) u_lod (
    .data(in_data),
    .pos (lod_pos),
    .zero(lod_zero)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_adv)  s1_valid  <= in_valid;
      if (out_adv) out_valid <= s1_valid;
    end
  end

  // NOTE: the stage-1 payload needs no reset; it is only ever read while s1_valid is set.
  always_ff @(posedge clk) begin
    if (in_valid && s1_adv) begin
      s1_data <= in_data;
      s1_pos  <= lod_pos;
      s1_zero <= lod_zero;
    end
  end

  // Normalise so the leading one lands in the MSB, then drop it; the shift is lossless.
  always_comb begin
    shamt      = POS_WIDTH'(DATA_WIDTH - 1) - s1_pos;
    out_d.frac = (DATA_WIDTH-1)'(s1_data << shamt);
    out_d.exp  = EXP_WIDTH'(s1_pos) - EXP_WIDTH'(FRAC_WIDTH);
    out_d.zero = 1'b0;
    if (s1_zero) begin
      out_d      = '0;
      out_d.zero = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else if (out_adv && s1_valid) begin
      out_q <= out_d;
    end
  end

  assign out_frac = out_q.frac;
  assign out_exp  = out_q.exp;
  assign out_zero = out_q.zero;

endmodule

// File: tb/tb_ln_range_reduce.sv
// Directed bench for ln_range_reduce: vector table, full-code stream, backpressure and mid-flight reset.
module tb_ln_range_reduce;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] out_frac;
  logic [3:0] out_exp;
  logic       out_zero;
  logic       out_valid;
  logic       out_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] din;
    logic [6:0] frac;
    logic [3:0] exp;
    logic       zero;
  } vec_t;

  vec_t vecs [9];

  ln_range_reduce dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_frac (out_frac),
    .out_exp  (out_exp),
    .out_zero (out_zero),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One isolated sample with out_ready held high: nothing at +1 cycle, result at +2.
  task automatic apply_one(input vec_t v);
    out_ready = 1'b1;
    in_data   = v.din;
    in_valid  = 1'b1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'hA5;
    check("latency_not_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("vec_valid", 32'(out_valid), 32'd1);
    check($sformatf("vec_frac_%02h", v.din), 32'(out_frac), 32'(v.frac));
    check($sformatf("vec_exp_%02h", v.din), 32'(out_exp), 32'(v.exp));
    check($sformatf("vec_zero_%02h", v.din), 32'(out_zero), 32'(v.zero));
    @(posedge clk); #1;
    check("vec_drained", 32'(out_valid), 32'd0);
  endtask

  logic [7:0] bp_in   [3];
  logic [6:0] bp_frac [3];
  logic [3:0] bp_exp  [3];

  initial begin
    int         n;
    int         first_cyc;
    int         last_cyc;
    int         rdy_low;
    int         e;
    logic [31:0] recon;
    int         idx;
    int         got;
    int         inflight;
    int         stall_left;
    bit         stalled_once;
    bit         in_fire;
    bit         out_fire;
    logic [11:0] snap;
    int         leaked;

    vecs[0] = '{din: 8'h30, frac: 7'h40, exp: 4'h1, zero: 1'b0};
    vecs[1] = '{din: 8'h01, frac: 7'h00, exp: 4'hC, zero: 1'b0};
    vecs[2] = '{din: 8'hFF, frac: 7'h7F, exp: 4'h3, zero: 1'b0};
    vecs[3] = '{din: 8'h10, frac: 7'h00, exp: 4'h0, zero: 1'b0};
    vecs[4] = '{din: 8'h00, frac: 7'h00, exp: 4'h0, zero: 1'b1};
    vecs[5] = '{din: 8'h08, frac: 7'h00, exp: 4'hF, zero: 1'b0};
    vecs[6] = '{din: 8'h0B, frac: 7'h30, exp: 4'hF, zero: 1'b0};
    vecs[7] = '{din: 8'h80, frac: 7'h00, exp: 4'h3, zero: 1'b0};
    vecs[8] = '{din: 8'h20, frac: 7'h00, exp: 4'h1, zero: 1'b0};

    bp_in   = '{8'h30, 8'h01, 8'hFF};
    bp_frac = '{7'h40, 7'h00, 7'h7F};
    bp_exp  = '{4'h1, 4'hC, 4'h3};

    // Reset held three cycles with a valid input present.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h30;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", {20'd0, out_frac, out_exp, out_zero}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_no_output", 32'(out_valid), 32'd0);

    // Directed table.
    for (int i = 0; i < 8; i++) apply_one(vecs[i]);

    // All 256 codes back-to-back; each result must satisfy the exactness identity.
    n = 0; first_cyc = -1; last_cyc = -1; rdy_low = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && n < 256; cyc++) begin
      in_valid = (cyc < 256);
      in_data  = 8'(cyc);
      #1;
      if (cyc < 256 && !in_ready) rdy_low++;
      @(posedge clk); #1;
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (n == 0) begin
          check("stream_zero", {20'd0, out_zero, out_frac, out_exp}, 32'h800);
        end else begin
          e = int'($signed(out_exp)) + 4;
          recon = (e >= 0 && e <= 7) ? ((32'd128 + 32'(out_frac)) << e) : 32'hFFFF_FFFF;
          check($sformatf("stream_exact_%02h", n), recon, 32'(n) << 7);
          check("stream_nonzero_flag", 32'(out_zero), 32'd0);
        end
        n++;
      end
    end
    in_valid = 1'b0;
    check("stream_count", 32'(n), 32'd256);
    check("stream_back_to_back", 32'(last_cyc - first_cyc + 1), 32'd256);
    check("stream_in_ready_high", 32'(rdy_low), 32'd0);
    @(posedge clk); #1;
    check("stream_drained", 32'(out_valid), 32'd0);

    // Backpressure: stall 4 cycles right after the first result appears.
    idx = 0; got = 0; inflight = 0; stall_left = 0; stalled_once = 1'b0; snap = '0;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      if (out_valid && !stalled_once) begin
        stall_left   = 4;
        stalled_once = 1'b1;
        snap         = {out_frac, out_exp, out_zero};
      end
      out_ready = (stall_left == 0);
      in_valid  = (idx < 3);
      in_data   = (idx < 3) ? bp_in[idx] : 8'h5A;
      #1;
      if (!out_ready) begin
        check("bp_hold", {19'd0, out_valid, out_frac, out_exp, out_zero}, {19'd0, 1'b1, snap});
        check("bp_in_ready", 32'(in_ready), (inflight == 2) ? 32'd0 : 32'd1);
      end
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        if (got < 3) begin
          check($sformatf("bp_frac_%0d", got), 32'(out_frac), 32'(bp_frac[got]));
          check($sformatf("bp_exp_%0d", got), 32'(out_exp), 32'(bp_exp[got]));
        end
        got++;
      end
      @(posedge clk); #1;
      if (in_fire) begin idx++; inflight++; end
      if (out_fire) inflight--;
      if (stall_left > 0) stall_left--;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", 32'(got), 32'd3);
    check("bp_stall_seen", 32'(stalled_once), 32'd1);
    @(posedge clk); #1;
    check("bp_no_duplicate", 32'(out_valid), 32'd0);

    // Reset with both stages full: the in-flight samples must vanish.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h30;
    @(posedge clk); #1;
    in_data = 8'h01;
    @(posedge clk); #1;
    check("mid_full_in_ready", 32'(in_ready), 32'd0);
    rst     = 1'b1;
    in_data = 8'h55;
    @(posedge clk); #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    leaked    = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) leaked++;
    end
    check("mid_rst_no_leak", 32'(leaked), 32'd0);
    apply_one(vecs[8]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
